// File: rtl/ir_pkg.sv
// Shared types and constants for the multi-channel IR line counter.
package ir_pkg;

    localparam logic [1:0] MODE_ENTER = 2'b00;
    localparam logic [1:0] MODE_EXIT  = 2'b01;
    localparam logic [1:0] MODE_BOTH  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CHARGE,
        DISCHARGE,
        EVAL
    } ir_state_e;

    function automatic int tw_calc(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/ir_channel_track.sv
// One sensor channel: discharge-time latch, threshold compare, debounce,
// edge qualification and saturating counter. IR_RAW_TIME_EN adds raw_time_o.
module ir_channel_track
    import ir_pkg::*;
#(
    parameter int TW         = 11,
    parameter int MIN_STABLE = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             charge_i,
    input  logic             disch_i,
    input  logic             eval_i,
    input  logic             clear_i,
    input  logic             timeout_i,
    input  logic [TW-1:0]    t_i,
    input  logic             sync_i,
    input  logic [TW-1:0]    threshold_i,
    input  logic [1:0]       mode_i,
    output logic             done_o,
    output logic             is_black_o,
    output logic             edge_o,
    output logic [CNT_W-1:0] count_o,
`ifdef IR_RAW_TIME_EN
    output logic [TW-1:0]    raw_time_o,
`endif
    output logic             ovf_o
);

    localparam int SW = $clog2(MIN_STABLE + 1);

    logic [TW-1:0]    time_q, time_d;
    logic             latched_q, latched_d;
    logic [SW-1:0]    stab_q, stab_d;
    logic             black_q, black_d;
    logic             edge_q, edge_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             raw;
    logic             counted;

    assign done_o     = latched_q | ~sync_i;
    assign is_black_o = black_q;
    assign edge_o     = edge_q;
    assign count_o    = cnt_q;
    assign ovf_o      = ovf_q;
    assign raw        = (time_q >= threshold_i);

    // A channel still high at the timeout cycle latches t, which equals TIMEOUT.
    always_comb begin
        time_d    = time_q;
        latched_d = latched_q;
        if (charge_i) begin
            latched_d = 1'b0;
        end else if (disch_i && !latched_q && (!sync_i || timeout_i)) begin
            time_d    = t_i;
            latched_d = 1'b1;
        end
    end

    always_comb begin
        stab_d  = stab_q;
        black_d = black_q;
        counted = 1'b0;
        if (eval_i) begin
            if (raw != black_q) begin
                if (stab_q == SW'(MIN_STABLE - 1)) begin
                    black_d = ~black_q;
                    stab_d  = '0;
                    case (mode_i)
                        MODE_ENTER:       counted = ~black_q;
                        MODE_EXIT:        counted = black_q;
                        MODE_BOTH, 2'b11: counted = 1'b1;
                        default:          counted = 1'b0;
                    endcase
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end else begin
                stab_d = '0;
            end
        end
    end

    // Clear takes priority over a same-cycle increment; the pulse still fires.
    always_comb begin
        edge_d = counted;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;
        if (clear_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (counted) begin
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            time_q    <= '0;
            latched_q <= 1'b0;
            stab_q    <= '0;
            black_q   <= 1'b0;
            edge_q    <= 1'b0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            time_q    <= time_d;
            latched_q <= latched_d;
            stab_q    <= stab_d;
            black_q   <= black_d;
            edge_q    <= edge_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef IR_RAW_TIME_EN
    logic [TW-1:0] raw_time_q, raw_time_d;

    always_comb begin
        raw_time_d = raw_time_q;
        if (eval_i) begin
            raw_time_d = time_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            raw_time_q <= '0;
        end else begin
            raw_time_q <= raw_time_d;
        end
    end

    assign raw_time_o = raw_time_q;
`endif

endmodule

// File: rtl/ir_line_counter_multi.sv
// Multi-channel RC reflectance measurement: shared charge/discharge FSM
// driving CHANNELS trackers. Define IR_RAW_TIME_EN to export raw_time.
module ir_line_counter_multi
    import ir_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int TIMEOUT       = 2000,
    parameter int CHARGE_CYCLES = 10,
    parameter int MIN_STABLE    = 2,
    parameter int CNT_W         = 8,
    localparam int TW           = tw_calc(TIMEOUT)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [1:0]                mode,
    input  logic [TW-1:0]             threshold,
    input  logic [CHANNELS-1:0]       sensor_in,
    output logic                      sensor_oe,
    output logic [CHANNELS-1:0]       is_black,
    output logic [CHANNELS-1:0]       edge_pulse,
    output logic [CHANNELS*CNT_W-1:0] counts,
    output logic [CHANNELS-1:0]       overflow,
`ifdef IR_RAW_TIME_EN
    output logic [CHANNELS*TW-1:0]    raw_time,
`endif
    output logic                      sample_valid
);

    localparam int CCW = (CHARGE_CYCLES > 1) ? $clog2(CHARGE_CYCLES) : 1;

    ir_state_e           state_q, state_d;
    logic [CCW-1:0]      charge_cnt_q, charge_cnt_d;
    logic [TW-1:0]       t_q, t_d;
    logic [CHANNELS-1:0] sync1_q, sync2_q;
    logic                sample_valid_q;
    logic [CHANNELS-1:0] done;
    logic                timeout_hit;

    assign timeout_hit  = (t_q == TW'(TIMEOUT));
    assign sensor_oe    = (state_q == CHARGE);
    assign sample_valid = sample_valid_q;

    // Enable is only looked at in IDLE, so a started measurement always completes.
    always_comb begin
        state_d      = state_q;
        charge_cnt_d = charge_cnt_q;
        t_d          = t_q;
        case (state_q)
            IDLE: begin
                charge_cnt_d = '0;
                t_d          = '0;
                if (enable) begin
                    state_d = CHARGE;
                end
            end
            CHARGE: begin
                if (charge_cnt_q == CCW'(CHARGE_CYCLES - 1)) begin
                    state_d      = DISCHARGE;
                    charge_cnt_d = '0;
                end else begin
                    charge_cnt_d = charge_cnt_q + 1'b1;
                end
            end
            DISCHARGE: begin
                if ((&done) || timeout_hit) begin
                    state_d = EVAL;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            EVAL: begin
                state_d = IDLE;
                t_d     = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            charge_cnt_q   <= '0;
            t_q            <= '0;
            sync1_q        <= '0;
            sync2_q        <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            charge_cnt_q   <= charge_cnt_d;
            t_q            <= t_d;
            sync1_q        <= sensor_in;
            sync2_q        <= sync1_q;
            sample_valid_q <= (state_q == EVAL);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        ir_channel_track #(
            .TW         (TW),
            .MIN_STABLE (MIN_STABLE),
            .CNT_W      (CNT_W)
        ) u_track (
            .clock       (clock),
            .reset       (reset),
            .charge_i    (state_q == CHARGE),
            .disch_i     (state_q == DISCHARGE),
            .eval_i      (state_q == EVAL),
            .clear_i     (clear),
            .timeout_i   (timeout_hit),
            .t_i         (t_q),
            .sync_i      (sync2_q[i]),
            .threshold_i (threshold),
            .mode_i      (mode),
            .done_o      (done[i]),
            .is_black_o  (is_black[i]),
            .edge_o      (edge_pulse[i]),
            .count_o     (counts[i*CNT_W +: CNT_W]),
`ifdef IR_RAW_TIME_EN
            .raw_time_o  (raw_time[i*TW +: TW]),
`endif
            .ovf_o       (overflow[i])
        );
    end

endmodule

// File: doc/ir_line_counter_multi.md
Name: ir_line_counter_multi

Overview:
Multi-channel successor to the single-channel infrared state/count block. One shared FSM runs RC charge/discharge measurements on CHANNELS reflectance sensors. Each channel's discharge time is compared with a runtime threshold, debounced, and turned into black/white state plus edge counts. Selectable edge mode and saturating counters. Sits between the sensor pads (tristate at top level) and the NIOS register bank.

Parameters:
CHANNELS, 4, number of sensors (1..16)
TIMEOUT, 2000, max discharge cycles; TW = $clog2(TIMEOUT+1)
CHARGE_CYCLES, 10, cycles pads are driven high before release
MIN_STABLE, 2, consecutive equal raw samples required to change is_black (>=1)
CNT_W, 8, width of each per-channel counter

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
enable  in  1  start/continue measurement cycles
clear  in  1  synchronous clear of counts and overflow
mode  in  2  00 count white->black, 01 black->white, 10/11 both
threshold  in  TW  discharge time >= threshold means black
sensor_in  in  CHANNELS  pad inputs (asynchronous)
sensor_oe  out  1  1 = drive pads high (charge), 0 = release
is_black  out  CHANNELS  debounced state per channel
edge_pulse  out  CHANNELS  1-cycle pulse on counted transition
counts  out  CHANNELS*CNT_W  packed counters, channel 0 in LSBs
overflow  out  CHANNELS  sticky, set on saturation attempt
sample_valid  out  1  1-cycle pulse when new results are visible

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE, sensor_oe=0, all timers 0, is_black=0, debounce counters 0, counts=0, overflow=0, edge_pulse=0, sample_valid=0.
- sensor_in passes through a 2-flop synchroniser before use.
- FSM IDLE: if enable, go to CHARGE. CHARGE: sensor_oe=1 for exactly CHARGE_CYCLES cycles, then DISCHARGE.
- DISCHARGE: sensor_oe=0. Timer t starts at 0 and increments each cycle. Channel i latches time_i=t on the first cycle its synchronised input is 0. DISCHARGE ends when all channels have latched or t==TIMEOUT. Unlatched channels get time_i=TIMEOUT. Then EVAL.
- EVAL (1 cycle): raw_i = (time_i >= threshold). threshold and mode are sampled here, so changes apply from the next EVAL.
- Debounce: if raw_i differs from is_black[i], increment stab_i, else clear it. When stab_i reaches MIN_STABLE, toggle is_black[i] and clear stab_i. With MIN_STABLE=1, is_black follows raw every sample.
- Counted transition per mode raises edge_pulse[i] and counts[i]+1. At all-ones the counter holds and overflow[i] is set.
- is_black, counts, overflow, edge_pulse and sample_valid register on the EVAL->IDLE edge, so they are visible in the following IDLE cycle. Pulses last 1 cycle.
- Period = 1 + CHARGE_CYCLES + discharge cycles + 1. Back-to-back while enable stays high.
- enable low mid-cycle: current measurement completes through EVAL, then FSM stays in IDLE.
- clear and a counted edge in the same cycle: clear wins (count 0, overflow 0). edge_pulse still fires. clear does not affect is_black or the FSM.
- threshold=0: always black. threshold>TIMEOUT: always white.

Optional Feature:
Macro IR_RAW_TIME_EN.
- Defined: adds output raw_time (CHANNELS*TW), the latched time_i of every channel, updated together with sample_valid. Reset value 0.
- Undefined: port absent and time latches are only used internally.

Decomposition:
- Package ir_pkg: mode encoding constants (MODE_ENTER, MODE_EXIT, MODE_BOTH), FSM state typedef (IDLE, CHARGE, DISCHARGE, EVAL), TW helper function.
- Sub-module ir_channel_track: per channel, holds time latch, threshold compare, debounce, edge detect and saturating counter. Generated CHANNELS times under the shared FSM.

Test Plan:
(All with CHANNELS=4, TIMEOUT=100, CHARGE_CYCLES=10, MIN_STABLE=2, threshold=50, mode=00.)
- Reset: assert reset=0 mid-DISCHARGE -> all outputs 0 immediately. Release -> sensor_oe rises after 1 IDLE cycle and stays high exactly 10 cycles.
- Ch0 falls at t=70 and others at t=10, for 2 samples -> is_black=0001 after the 2nd sample_valid, edge_pulse[0] once, counts[0]=1. A single 70 sample between 10s causes no change.
- No input ever falls -> DISCHARGE lasts 101 cycles, all time_i=100, all black after 2 samples. Period = 1+10+101+1 = 113 cycles.
- mode=10, ch1 toggles black/white 5 full times -> counts[1]=10. Under mode=01 the same stimulus gives 5.
- CNT_W=4, 20 entries on ch2 -> counts[2]=15, overflow[2]=1. clear asserted on the same cycle as an edge -> counts 0, overflow 0, edge_pulse still high.
- enable dropped in CHARGE -> cycle finishes, exactly one sample_valid, then FSM stays in IDLE with sensor_oe=0. With IR_RAW_TIME_EN, raw_time for ch0 = 70.
